pixel_array_sequencer: RTL
==========================

// Module: pixel_array_sequencer
// PURPOSE
//  Parametrised frame sequencer and readout engine for an N-row pixel array.
//  - Drives erase/expose/convert and one-hot row-read strobes.
//  - Generates the ADC ramp code counter during conversion.
//  - Streams each row's 8-bit-class sample out through a valid/ready port.
//  - Successor to the fixed 4-read top: row count, code width and exposure time
//    are configurable, and it adds continuous-frame mode and output back-pressure.
// PARAMETERS
//  NUM_ROWS   4    number of row-read strobes (>=1)
//  DATA_W     8    pixel code width; ramp runs 0..2**DATA_W-1
//  ERASE_CYC  5    clock cycles erase is held high (>=1)
//  EXP_W      16   width of runtime exposure-length input
// PORTS
//  clk          in   1                  clock, rising edge
//  reset        in   1                  async, active-low; 0 = reset
//  start        in   1                  pulse: begin one frame (ignored while busy)
//  cont         in   1                  1 = auto-restart next frame after readout
//  expose_len   in   EXP_W              exposure cycles; sampled on start; 0 treated as 1
//  erase        out  1                  pixel erase strobe
//  expose       out  1                  pixel expose strobe
//  convert      out  1                  ramp/compare phase strobe
//  ramp_code    out  DATA_W             code fed to the pixel latches during convert
//  read         out  NUM_ROWS           one-hot row-read strobes
//  pix_data     in   DATA_W             shared pixel data bus (valid 1 cycle after read[r] rises)
//  out_data     out  DATA_W             captured row sample
//  out_row      out  $clog2(NUM_ROWS)   row index of out_data (min width 1)
//  out_valid    out  1                  out_data/out_row valid
//  out_ready    in   1                  sink accepts when out_valid & out_ready
//  busy         out  1                  high in every state except IDLE
//  frame_done   out  1                  1-cycle pulse after last row accepted
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; row ptr 0; ramp_code 0.
//    Reset asserted mid-frame aborts immediately; no partial frame_done.
//  - IDLE: on start, latch expose_len -> ERASE.
//  - ERASE: erase=1 for exactly ERASE_CYC cycles -> EXPOSE.
//  - EXPOSE: expose=1 for max(latched expose_len,1) cycles -> CONVERT.
//  - CONVERT: convert=1; ramp_code=0 on first cycle, +1 per cycle; 2**DATA_W cycles total;
//    after code all-ones -> RD_SETUP, row=0. ramp_code returns to 0 on leaving.
//  - RD_SETUP: read[row]=1; next cycle capture pix_data into out_data, out_row=row -> RD_HOLD.
//  - RD_HOLD: read[row] stays 1; out_valid=1; out_data/out_row stable until handshake.
//    On out_valid&out_ready: out_valid=0 next cycle; if row<NUM_ROWS-1: row+1 -> RD_SETUP,
//    else -> DONE. Minimum 2 cycles per row; out_ready held low stalls indefinitely.
//  - DONE: frame_done=1 for one cycle; if cont=1 (sampled here) re-latch expose_len -> ERASE,
//    else -> IDLE.
//  - At most one of erase/expose/convert/|read is high in any cycle; read always one-hot or 0.
//  - start while busy: ignored (no queueing). start and cont both low in DONE -> IDLE.
//  - Counters sized to hold ERASE_CYC, 2**EXP_W-1 and 2**DATA_W without overflow;
//    no wrap-around anywhere.
// CONFIGURATION
//  PIXSEQ_TESTPAT_EN:
//    defined -> extra input test_pat (1 bit). When test_pat=1, RD_SETUP capture loads
//               out_data = {frame_cnt[DATA_W-1-ROWW:0], row} instead of pix_data.
//               frame_cnt is an internal DATA_W-bit counter, +1 per DONE, wraps, reset 0.
//    undefined -> no test_pat port, no frame counter; out_data always from pix_data.
// STRUCTURE
//  - Package pixel_seq_pkg: state enum (IDLE, ERASE, EXPOSE, CONVERT, RD_SETUP, RD_HOLD, DONE),
//    default DATA_W/NUM_ROWS constants.
//  - One sub-module: pixel_out_reg (capture register plus valid/ready hold logic).
//  - FSM and phase counters stay in this module.
// TESTING
//  1 Reset mid-CONVERT (ramp_code=0x40) -> all outputs 0 at once; IDLE; start then runs a clean frame.
//  2 start, expose_len=3, out_ready=1 -> erase 5 cyc, expose 3 cyc, convert 256 cyc
//    (ramp 0..255), rows 0..3 each 2 cyc, frame_done one pulse, then IDLE.
//  3 expose_len=0 -> expose high exactly 1 cycle.
//  4 out_ready low 10 cyc on row 2 -> read[2], out_data, out_row=2 held stable;
//    row 3 starts only after accept.
//  5 cont=1 -> DONE goes straight to ERASE; start pulses during busy have no effect; 3 frames back-to-back.
//  6 PIXSEQ_TESTPAT_EN, test_pat=1 -> frame 0 yields out_data 0,1,2,3; frame 1 yields 4,5,6,7.

Source files
------------

// File: rtl/pixel_seq_pkg.sv
// pixel_seq_pkg
//   Shared definitions for the pixel array sequencer:
//   - state_t  : frame sequencer state encoding
//   - DEF_*    : default pixel code width and row count
//   - row_w()  : row-index width, never narrower than one bit
package pixel_seq_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_ROWS = 4;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        RD_SETUP,
        RD_HOLD,
        DONE
    } state_t;

    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_out_reg.sv
// pixel_out_reg
//   Output capture register with valid/ready hold.
//   A load pulse captures din/rin and raises out_valid. The captured values
//   stay stable until the sink accepts (out_valid & out_ready), after which
//   out_valid drops on the following cycle.
// Ports
//   clk        in   clock, rising edge
//   reset      in   async, active-low
//   load       in   capture din/rin this cycle
//   din        in   DATA_W sample to capture
//   rin        in   ROWW row index to capture
//   out_ready  in   sink ready
//   out_data   out  captured sample
//   out_row    out  captured row index
//   out_valid  out  captured values valid
module pixel_out_reg #(
    parameter int DATA_W = 8,
    parameter int ROWW   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic [ROWW-1:0]   rin,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ROWW-1:0]   out_row,
    output logic              out_valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_row   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= din;
            out_row   <= rin;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_array_sequencer.sv
// pixel_array_sequencer
//   Frame sequencer and readout engine for an N-row pixel array:
//   ERASE -> EXPOSE -> CONVERT (ADC ramp) -> per-row read -> DONE, with
//   optional continuous-frame restart and valid/ready output back-pressure.
// Configuration
//   PIXSEQ_TESTPAT_EN : adds input test_pat; when high the row capture loads
//                       {frame counter, row} instead of pix_data.
// Ports
//   clk         in   clock, rising edge
//   reset       in   async, active-low
//   start       in   begin one frame (ignored while busy)
//   cont        in   restart next frame automatically, sampled in DONE
//   expose_len  in   exposure cycles, latched at frame start; 0 acts as 1
//   test_pat    in   (PIXSEQ_TESTPAT_EN only) select test pattern capture
//   erase       out  erase strobe
//   expose      out  expose strobe
//   convert     out  ramp/compare strobe
//   ramp_code   out  ADC ramp code
//   read        out  one-hot row-read strobes
//   pix_data    in   shared pixel data bus
//   out_data    out  captured row sample
//   out_row     out  row index of out_data
//   out_valid   out  output valid
//   out_ready   in   sink ready
//   busy        out  high outside IDLE
//   frame_done  out  one-cycle end-of-frame pulse
module pixel_array_sequencer
    import pixel_seq_pkg::*;
#(
    parameter int NUM_ROWS  = DEF_NUM_ROWS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ERASE_CYC = 5,
    parameter int EXP_W     = 16,
    localparam int ROWW     = row_w(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                cont,
    input  logic [EXP_W-1:0]    expose_len,
`ifdef PIXSEQ_TESTPAT_EN
    input  logic                test_pat,
`endif
    output logic                erase,
    output logic                expose,
    output logic                convert,
    output logic [DATA_W-1:0]   ramp_code,
    output logic [NUM_ROWS-1:0] read,
    input  logic [DATA_W-1:0]   pix_data,
    output logic [DATA_W-1:0]   out_data,
    output logic [ROWW-1:0]     out_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                frame_done
);

    localparam int ERASE_W = $clog2(ERASE_CYC + 1);
    localparam int CNT_W   = (EXP_W > ERASE_W) ? EXP_W : ERASE_W;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [EXP_W-1:0]  exp_last_q;
    logic [EXP_W-1:0]  exp_last_new;
    logic [ROWW-1:0]   row_q;
    logic [DATA_W-1:0] ramp_q;
    logic [DATA_W-1:0] cap_data;
    logic              last_row;
    logic              accept;
    logic              load;
    logic              latch_exp;

    // Store the final exposure count index so a zero length still gives one cycle.
    assign exp_last_new = (expose_len == '0) ? '0 : expose_len - EXP_W'(1);
    assign last_row     = (row_q == ROWW'(NUM_ROWS - 1));
    assign accept       = out_valid & out_ready;
    assign latch_exp    = ((state_q == IDLE) && start) || ((state_q == DONE) && cont);
    assign ramp_code    = ramp_q;

    always_comb begin
        state_d    = state_q;
        erase      = 1'b0;
        expose     = 1'b0;
        convert    = 1'b0;
        read       = '0;
        frame_done = 1'b0;
        load       = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) state_d = ERASE;
            end
            ERASE: begin
                erase = 1'b1;
                if (cnt_q == CNT_W'(ERASE_CYC - 1)) state_d = EXPOSE;
            end
            EXPOSE: begin
                expose = 1'b1;
                if (cnt_q == CNT_W'(exp_last_q)) state_d = CONVERT;
            end
            CONVERT: begin
                convert = 1'b1;
                if (ramp_q == '1) state_d = RD_SETUP;
            end
            RD_SETUP: begin
                read[row_q] = 1'b1;
                load        = 1'b1;
                state_d     = RD_HOLD;
            end
            RD_HOLD: begin
                read[row_q] = 1'b1;
                if (accept) state_d = last_row ? DONE : RD_SETUP;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = cont ? ERASE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            exp_last_q <= '0;
            row_q      <= '0;
            ramp_q     <= '0;
        end else begin
            state_q <= state_d;

            // Phase counter restarts on every state change and idles at zero
            // outside the timed phases, so it never wraps.
            if ((state_d != state_q) || !((state_q == ERASE) || (state_q == EXPOSE)))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CNT_W'(1);

            if (latch_exp) exp_last_q <= exp_last_new;

            if ((state_q == CONVERT) && (state_d == CONVERT))
                ramp_q <= ramp_q + DATA_W'(1);
            else
                ramp_q <= '0;

            if ((state_q != RD_SETUP) && (state_q != RD_HOLD))
                row_q <= '0;
            else if ((state_q == RD_HOLD) && accept && !last_row)
                row_q <= row_q + ROWW'(1);
        end
    end

`ifdef PIXSEQ_TESTPAT_EN
    // Only the low DATA_W-ROWW bits of the frame counter ever reach out_data,
    // so the counter is kept at that width; wrap behaviour at the output is identical.
    localparam int FC_W = DATA_W - ROWW;
    logic [FC_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_cnt_q <= '0;
        else if (state_q == DONE)
            frame_cnt_q <= frame_cnt_q + FC_W'(1);
    end

    assign cap_data = test_pat ? {frame_cnt_q, row_q} : pix_data;
`else
    assign cap_data = pix_data;
`endif

    pixel_out_reg #(
        .DATA_W (DATA_W),
        .ROWW   (ROWW)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .din       (cap_data),
        .rin       (row_q),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_valid (out_valid)
    );

endmodule
